// File: rtl/rv_mc_pkg.sv
// Shared types for the multi-cycle RV32 subset core: FSM states, opcodes, ALU ops.
package rv_mc_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [2:0] {
        OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_BEQ, OPC_BAD
    } opclass_t;

    typedef enum logic [2:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
    } alu_op_t;

    function automatic opclass_t decode_op(input logic [6:0] op);
        case (op)
            OP_R:    decode_op = OPC_R;
            OP_I:    decode_op = OPC_I;
            OP_LW:   decode_op = OPC_LW;
            OP_SW:   decode_op = OPC_SW;
            OP_BEQ:  decode_op = OPC_BEQ;
            default: decode_op = OPC_BAD;
        endcase
    endfunction

    // Address generation for lw/sw is a plain add; unlisted funct3 also fall back to add.
    function automatic alu_op_t alu_sel(input opclass_t opc, input logic [2:0] f3, input logic f7b5);
        alu_sel = ALU_ADD;
        if (opc == OPC_R || opc == OPC_I) begin
            case (f3)
                3'b000:  alu_sel = (opc == OPC_R && f7b5) ? ALU_SUB : ALU_ADD;
                3'b010:  alu_sel = ALU_SLT;
                3'b110:  alu_sel = ALU_OR;
                3'b111:  alu_sel = ALU_AND;
                default: alu_sel = ALU_ADD;
            endcase
        end
    endfunction

endpackage

// File: rtl/mc_control_fsm.sv
// Control sequencer: one state register plus registered bus/retire/trap strobes.
module mc_control_fsm
    import rv_mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_mem_ready,
    input  logic [2:0] i_opclass,
    output logic [2:0] o_state,
    output logic       o_mem_req,
    output logic       o_mem_we,
    output logic       o_retire,
    output logic       o_trap
);

    state_t   r_state;
    state_t   w_next;
    opclass_t w_opc;
    logic     r_mem_req, r_mem_we, r_retire, r_trap;
    logic     w_xfer, w_done;

    assign w_opc  = opclass_t'(i_opclass);
    assign w_xfer = r_mem_req & i_mem_ready;

    always_comb begin
        w_next = r_state;
        w_done = 1'b0;
        case (r_state)
            S_FETCH:  if (w_xfer) w_next = S_DECODE;
            S_DECODE: w_next = (w_opc == OPC_BAD) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (w_opc)
                    OPC_R, OPC_I:   w_next = S_WB;
                    OPC_LW, OPC_SW: w_next = S_MEM;
                    OPC_BEQ: begin
                        w_next = S_FETCH;
                        w_done = 1'b1;
                    end
                    default:        w_next = S_TRAP;
                endcase
            end
            S_MEM: begin
                if (w_xfer) begin
                    w_next = (w_opc == OPC_SW) ? S_FETCH : S_WB;
                    w_done = (w_opc == OPC_SW);
                end
            end
            S_WB: begin
                w_next = S_FETCH;
                w_done = 1'b1;
            end
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    // mem_req comes up one cycle after reset release, so the first fetch
    // cycle out of reset is a request-setup cycle with the bus idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= S_FETCH;
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_retire  <= 1'b0;
            r_trap    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_mem_req <= (w_next == S_FETCH) || (w_next == S_MEM);
            r_mem_we  <= (w_next == S_MEM) && (w_opc == OPC_SW);
            r_retire  <= w_done;
            r_trap    <= (w_next == S_TRAP);
        end
    end

    assign o_state   = r_state;
    assign o_mem_req = r_mem_req;
    assign o_mem_we  = r_mem_we;
    assign o_retire  = r_retire;
    assign o_trap    = r_trap;

endmodule

// File: rtl/multi_cycle_top.sv
// Multi-cycle RV32 subset core: datapath registers and register file around mc_control_fsm.
module multi_cycle_top
    import rv_mc_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              NREGS    = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_ready,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] PC_Out,
    output logic [XLEN-1:0] Result_Out,
    output logic            retire,
    output logic            trap
);

    localparam int RW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0] r_pc, r_ir_pc, r_a, r_b, r_imm, r_aluout, r_mdr, r_result;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_regs [NREGS];

    logic [2:0]        w_state_raw;
    state_t            w_state;
    opclass_t          w_opclass;
    alu_op_t           w_alu_op;
    logic              w_xfer;
    logic [RW-1:0]     w_rs1, w_rs2, w_rd;
    logic signed [31:0] w_imm32;
    logic [XLEN-1:0]   w_alu_b, w_alu_y, w_wb_data;

    assign w_state   = state_t'(w_state_raw);
    assign w_opclass = decode_op(r_ir[6:0]);
    assign w_alu_op  = alu_sel(w_opclass, r_ir[14:12], r_ir[30]);
    assign w_xfer    = mem_req & mem_ready;
    assign w_rs1     = r_ir[15 +: RW];
    assign w_rs2     = r_ir[20 +: RW];
    assign w_rd      = r_ir[7 +: RW];
    assign w_alu_b   = (w_opclass == OPC_R) ? r_b : r_imm;
    assign w_wb_data = (w_opclass == OPC_LW) ? r_mdr : r_aluout;

    mc_control_fsm u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_mem_ready (mem_ready),
        .i_opclass   (w_opclass),
        .o_state     (w_state_raw),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_retire    (retire),
        .o_trap      (trap)
    );

    always_comb begin
        w_imm32 = {{20{r_ir[31]}}, r_ir[31:20]};
        if (w_opclass == OPC_SW)
            w_imm32 = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
        else if (w_opclass == OPC_BEQ)
            w_imm32 = {{20{r_ir[31]}}, r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    end

    always_comb begin
        w_alu_y = r_a + w_alu_b;
        case (w_alu_op)
            ALU_SUB: w_alu_y = r_a - w_alu_b;
            ALU_AND: w_alu_y = r_a & w_alu_b;
            ALU_OR:  w_alu_y = r_a | w_alu_b;
            ALU_SLT: w_alu_y = ($signed(r_a) < $signed(w_alu_b)) ? XLEN'(1) : '0;
            default: ;
        endcase
    end

    // r_ir_pc keeps the fetch address because r_pc has already moved on by EXEC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc     <= RESET_PC;
            r_ir_pc  <= RESET_PC;
            r_ir     <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_imm    <= '0;
            r_aluout <= '0;
            r_mdr    <= '0;
            r_result <= '0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else begin
            case (w_state)
                S_FETCH: begin
                    if (w_xfer) begin
                        r_ir    <= 32'(mem_rdata);
                        r_ir_pc <= r_pc;
                        r_pc    <= r_pc + XLEN'(4);
                    end
                end
                S_DECODE: begin
                    r_a   <= r_regs[w_rs1];
                    r_b   <= r_regs[w_rs2];
                    r_imm <= XLEN'(w_imm32);
                end
                S_EXEC: begin
                    r_aluout <= w_alu_y;
                    if (w_opclass == OPC_BEQ && r_a == r_b) r_pc <= r_ir_pc + r_imm;
                end
                S_MEM: begin
                    if (w_xfer && !mem_we) r_mdr <= mem_rdata;
                end
                S_WB: begin
                    if (w_rd != '0) r_regs[w_rd] <= w_wb_data;
                    r_result <= w_wb_data;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr   = (w_state == S_MEM) ? r_aluout : r_pc;
    assign mem_wdata  = r_b;
    assign PC_Out     = r_pc;
    assign Result_Out = r_result;

endmodule

// File: tb/tb_multi_cycle_top.sv
// Directed bench for multi_cycle_top: small programs in a word memory, checked with immediate assertions.
module tb_multi_cycle_top;

    localparam logic [6:0] OPI = 7'b0010011;
    localparam logic [6:0] OPL = 7'b0000011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_we, retire, trap;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, PC_Out, Result_Out;
    logic [31:0] mem [64];

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    multi_cycle_top #(.XLEN(32), .RESET_PC(32'h0), .NREGS(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .PC_Out     (PC_Out),
        .Result_Out (Result_Out),
        .retire     (retire),
        .trap       (trap)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk)
        if (mem_req && mem_we && mem_ready) mem[mem_addr[7:2]] <= mem_wdata;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    // Branch offset given in halfwords (byte offset / 2).
    function automatic logic [31:0] enc_b(input logic [12:1] off, input logic [4:0] rs2, input logic [4:0] rs1);
        return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], 7'b1100011};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_007F;
    endtask

    task automatic expect_fetch(input logic [31:0] a, input string tag, output int c);
        int n = 0;
        while (mem_req !== 1'b1 && n < 12) begin step(); n++; end
        chkb({tag, "_req"}, mem_req, 1'b1);
        chk({tag, "_addr"}, mem_addr, a);
        chkb({tag, "_we"}, mem_we, 1'b0);
        c = cyc;
        step();
    endtask

    task automatic wait_retire(input string tag, output int c);
        int n = 0;
        while (retire !== 1'b1 && n < 12) begin step(); n++; end
        chkb({tag, "_retire"}, retire, 1'b1);
        c = cyc;
    endtask

    task automatic run_alu(input logic [31:0] a, input logic [31:0] res, input string tag);
        int c;
        expect_fetch(a, tag, c);
        wait_retire(tag, c);
        chk({tag, "_res"}, Result_Out, res);
    endtask

    initial begin
        int n, c0, c1, c2, rcnt;

        // ---- arithmetic, store, load ----
        clear_mem();
        mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        mem[1] = enc_i(12'd7, 5'd0, 3'b000, 5'd2, OPI);
        mem[2] = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd3);
        mem[3] = enc_s(12'd0, 5'd3, 5'd0);
        mem[4] = enc_i(12'd0, 5'd0, 3'b010, 5'd4, OPL);
        mem[5] = enc_r(7'h00, 5'd1, 5'd4, 3'b000, 5'd5);
        rst = 1'b0; mem_ready = 1'b1;
        step(); step();
        chkb("rst_req", mem_req, 1'b0);
        chk("rst_pc", PC_Out, 32'h0);
        chk("rst_result", Result_Out, 32'h0);
        chkb("rst_retire", retire, 1'b0);
        chkb("rst_trap", trap, 1'b0);
        rst = 1'b1;
        n = 0;
        while (mem_req !== 1'b1 && n < 8) begin step(); n++; end
        chkb("a_first_req", mem_req, 1'b1);
        chk("a_first_addr", mem_addr, 32'h0);
        rcnt = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (retire === 1'b1) rcnt++;
        end
        chk("a_retire_cnt", 32'(rcnt), 32'd3);
        chk("a_add_res", Result_Out, 32'd12);
        chk("a_pc", PC_Out, 32'h0C);
        n = 0;
        while (!(mem_req === 1'b1 && mem_we === 1'b1) && n < 10) begin step(); n++; end
        chk("sw_latency", 32'(n), 32'd3);
        chkb("sw_we", mem_we, 1'b1);
        chk("sw_addr", mem_addr, 32'h0);
        chk("sw_data", mem_wdata, 32'd12);
        step();
        chkb("sw_retire", retire, 1'b1);
        chk("sw_mem0", mem[0], 32'd12);
        c0 = cyc;
        step();
        wait_retire("lw", c1);
        chk("lw_cycles", 32'(c1 - c0), 32'd5);
        chk("lw_res", Result_Out, 32'd12);
        step();
        wait_retire("add_x5", c2);
        chk("add_x5_cycles", 32'(c2 - c1), 32'd4);
        chk("add_x5_res", Result_Out, 32'd17);

        // ---- branches, x0, ALU ops ----
        rst = 1'b0;
        clear_mem();
        mem[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        mem[1]  = enc_i(12'd7, 5'd0, 3'b000, 5'd2, OPI);
        mem[2]  = enc_i(12'd9, 5'd1, 3'b000, 5'd0, OPI);
        mem[3]  = enc_r(7'h00, 5'd1, 5'd0, 3'b000, 5'd13);
        mem[4]  = enc_b(12'd4, 5'd1, 5'd1);
        mem[6]  = enc_b(12'd4, 5'd2, 5'd1);
        mem[7]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd6);
        mem[8]  = enc_r(7'h00, 5'd1, 5'd6, 3'b010, 5'd7);
        mem[9]  = enc_i(12'd3, 5'd2, 3'b111, 5'd8, OPI);
        mem[10] = enc_i(12'd8, 5'd1, 3'b110, 5'd9, OPI);
        mem[11] = enc_i(12'hFFD, 5'd6, 3'b010, 5'd10, OPI);
        mem[12] = enc_i(12'hFFF, 5'd6, 3'b010, 5'd11, OPI);
        mem[13] = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd12);
        mem[14] = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd14);
        mem[15] = enc_r(7'h00, 5'd6, 5'd1, 3'b010, 5'd15);
        step();
        rst = 1'b1;
        run_alu(32'h00, 32'd5, "b_addi1");
        run_alu(32'h04, 32'd7, "b_addi2");
        run_alu(32'h08, 32'd14, "b_addi_x0");
        run_alu(32'h0C, 32'd5, "b_x0_zero");
        expect_fetch(32'h10, "beq_t", c1);
        expect_fetch(32'h18, "beq_t_tgt", c2);
        chk("beq_t_cycles", 32'(c2 - c1), 32'd3);
        chk("beq_no_wb", Result_Out, 32'd5);
        expect_fetch(32'h1C, "beq_nt_tgt", c0);
        chk("beq_nt_cycles", 32'(c0 - c2), 32'd3);
        wait_retire("sub", c1);
        chk("sub_res", Result_Out, 32'hFFFF_FFFE);
        run_alu(32'h20, 32'd1, "slt_neg");
        run_alu(32'h24, 32'd3, "andi");
        run_alu(32'h28, 32'd13, "ori");
        run_alu(32'h2C, 32'd0, "slti_lt_false");
        run_alu(32'h30, 32'd1, "slti_true");
        run_alu(32'h34, 32'd5, "and");
        run_alu(32'h38, 32'd7, "or");
        run_alu(32'h3C, 32'd0, "slt_signed");

        // ---- fetch stall ----
        rst = 1'b0;
        clear_mem();
        mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        mem_ready = 1'b0;
        step();
        rst = 1'b1;
        n = 0;
        while (mem_req !== 1'b1 && n < 8) begin step(); n++; end
        c0 = cyc;
        chk("stall_addr0", mem_addr, 32'h0);
        for (int i = 1; i <= 3; i++) begin
            step();
            chkb("stall_req", mem_req, 1'b1);
            chk("stall_addr", mem_addr, 32'h0);
            chk("stall_pc", PC_Out, 32'h0);
        end
        mem_ready = 1'b1;
        wait_retire("stall", c1);
        chk("stall_cycles", 32'(c1 - c0), 32'd7);
        chk("stall_res", Result_Out, 32'd5);

        // ---- trap, then reset in the middle of a load ----
        rst = 1'b0;
        clear_mem();
        mem[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, OPI);
        step();
        rst = 1'b1;
        run_alu(32'h00, 32'd5, "t_addi");
        expect_fetch(32'h04, "t_bad", c0);
        n = 0;
        while (trap !== 1'b1 && n < 6) begin step(); n++; end
        chkb("trap_set", trap, 1'b1);
        chk("trap_pc", PC_Out, 32'h08);
        rcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (mem_req === 1'b1 || retire === 1'b1) rcnt++;
        end
        chk("trap_quiet", 32'(rcnt), 32'd0);
        chkb("trap_sticky", trap, 1'b1);
        chk("trap_pc_frozen", PC_Out, 32'h08);
        chk("trap_res_frozen", Result_Out, 32'd5);

        rst = 1'b0;
        #1;
        chkb("rst2_trap", trap, 1'b0);
        chkb("rst2_req", mem_req, 1'b0);
        chk("rst2_pc", PC_Out, 32'h0);
        clear_mem();
        mem[0]  = enc_i(12'h040, 5'd0, 3'b010, 5'd1, OPL);
        mem[16] = 32'hDEAD_BEEF;
        step();
        rst = 1'b1;
        expect_fetch(32'h00, "d_lw", c0);
        mem_ready = 1'b0;
        n = 0;
        while (mem_req !== 1'b1 && n < 8) begin step(); n++; end
        chk("d_mem_addr", mem_addr, 32'h40);
        chkb("d_mem_we", mem_we, 1'b0);
        step();
        chkb("d_mem_hold", mem_req, 1'b1);
        rst = 1'b0;
        #1;
        chkb("d_rst_req", mem_req, 1'b0);
        chk("d_rst_pc", PC_Out, 32'h0);
        step();
        rst = 1'b1;
        mem_ready = 1'b1;
        expect_fetch(32'h00, "d_refetch", c1);
        chkb("d_trap_clear", trap, 1'b0);
        wait_retire("d_lw_done", c2);
        chk("d_lw_res", Result_Out, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
